// File: rtl/spi_slave_fifo_if.sv
// rtl/spi_slave_fifo_if.sv - host-side bus of the SPI slave: TX holding register, RX FIFO, enables and status
interface spi_slave_fifo_if #(
  parameter int WIDTH    = 8,
  parameter int RX_DEPTH = 4
);
  localparam int CW = $clog2(RX_DEPTH + 1);

  logic             wr_en;
  logic             rd_en;
  logic [WIDTH-1:0] tx_data;
  logic             tx_wr;
  logic             tx_full;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             rx_rd;
  logic [CW-1:0]    rx_count;
  logic             rx_overflow;
  logic             tx_underrun;
  logic             frame_abort;
  logic             clr_status;

  modport slave (
    input  wr_en, rd_en, tx_data, tx_wr, rx_rd, clr_status,
    output tx_full, rx_data, rx_valid, rx_count, rx_overflow, tx_underrun, frame_abort
  );

  modport master (
    output wr_en, rd_en, tx_data, tx_wr, rx_rd, clr_status,
    input  tx_full, rx_data, rx_valid, rx_count, rx_overflow, tx_underrun, frame_abort
  );
endinterface

// File: rtl/spi_slave_fifo.sv
// rtl/spi_slave_fifo.sv - SPI slave clocked by SCLK with TX holding register and RX FIFO
module spi_slave_fifo #(
  parameter int WIDTH     = 8,
  parameter int RX_DEPTH  = 4,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic              SCLK,
  input  logic              reset,
  input  logic              CS,
  input  logic              MOSI,
  output wire               MISO,
  spi_slave_fifo_if.slave   bus
);
  localparam int CW = $clog2(RX_DEPTH + 1);
  localparam int PW = $clog2(RX_DEPTH);
  localparam int BW = $clog2(WIDTH);

  if (WIDTH < 2) begin : g_bad_width
    $error("spi_slave_fifo: WIDTH must be at least 2");
  end
  if (RX_DEPTH < 2 || (RX_DEPTH & (RX_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("spi_slave_fifo: RX_DEPTH must be a power of two, at least 2");
  end

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [WIDTH-1:0] tx_hold_q, tx_hold_d;
  logic             tx_full_q, tx_full_d;
  logic [WIDTH-1:0] mem_q [RX_DEPTH];
  logic [WIDTH-1:0] mem_d [RX_DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             rx_overflow_q, rx_overflow_d;
  logic             tx_underrun_q, tx_underrun_d;
  logic             frame_abort_q, frame_abort_d;

  logic [WIDTH-1:0] hold_eff;
  logic [WIDTH-1:0] rx_word;
  logic             push, pop, push_ok, ovf_set, consume, und_set;
  logic             miso_bit;

  // Both shift registers move in the wire order, so the same helper serves RX and TX.
  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] v, input logic b);
    if (LSB_FIRST) return {b, v[WIDTH-1:1]};
    else           return {v[WIDTH-2:0], b};
  endfunction

  function automatic logic lead_bit(input logic [WIDTH-1:0] v);
    if (LSB_FIRST) return v[0];
    else           return v[WIDTH-1];
  endfunction

  assign hold_eff = tx_full_q ? tx_hold_q : '0;
  assign rx_word  = shift_in(rx_shift_q, MOSI);

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    rx_shift_d    = rx_shift_q;
    tx_shift_d    = tx_shift_q;
    frame_abort_d = 1'b0;
    push          = 1'b0;
    consume       = 1'b0;
    und_set       = 1'b0;

    case (state_q)
      IDLE: begin
        if (!CS) begin
          rx_shift_d = rx_word;
          tx_shift_d = shift_in(hold_eff, 1'b0);
          bit_cnt_d  = BW'(1);
          state_d    = SHIFT;
          if (bus.rd_en) begin
            consume = 1'b1;
            und_set = !tx_full_q;
          end
        end
      end
      default: begin
        if (CS) begin
          state_d       = IDLE;
          bit_cnt_d     = '0;
          frame_abort_d = 1'b1;
        end else begin
          rx_shift_d = rx_word;
          tx_shift_d = shift_in(tx_shift_q, 1'b0);
          if (bit_cnt_q == BW'(WIDTH - 1)) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            push      = bus.wr_en;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
    endcase
  end

  // A write landing on the consuming start edge refills the register behind the departing word.
  always_comb begin
    tx_hold_d = tx_hold_q;
    tx_full_d = tx_full_q;
    if (consume) tx_full_d = 1'b0;
    if (bus.tx_wr && (!tx_full_q || consume)) begin
      tx_hold_d = bus.tx_data;
      tx_full_d = 1'b1;
    end
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    pop      = bus.rx_rd && (count_q != '0);
    push_ok  = push && ((count_q != CW'(RX_DEPTH)) || pop);
    ovf_set  = push && !push_ok;
    if (push_ok) begin
      mem_d[wr_ptr_q] = rx_word;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    rx_overflow_d = bus.clr_status ? 1'b0 : (rx_overflow_q | ovf_set);
    tx_underrun_d = bus.clr_status ? 1'b0 : (tx_underrun_q | und_set);
  end

  always_ff @(posedge SCLK or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      rx_shift_q    <= '0;
      tx_shift_q    <= '0;
      tx_hold_q     <= '0;
      tx_full_q     <= 1'b0;
      mem_q         <= '{default: '0};
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      rx_overflow_q <= 1'b0;
      tx_underrun_q <= 1'b0;
      frame_abort_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      rx_shift_q    <= rx_shift_d;
      tx_shift_q    <= tx_shift_d;
      tx_hold_q     <= tx_hold_d;
      tx_full_q     <= tx_full_d;
      mem_q         <= mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      rx_overflow_q <= rx_overflow_d;
      tx_underrun_q <= tx_underrun_d;
      frame_abort_q <= frame_abort_d;
    end
  end

  // Before the start edge the master already samples bit 1, so IDLE presents the holding register.
  assign miso_bit = (state_q == IDLE) ? lead_bit(hold_eff) : lead_bit(tx_shift_q);
  assign MISO     = (!CS && bus.rd_en) ? miso_bit : 1'bz;

  assign bus.tx_full     = tx_full_q;
  assign bus.rx_data     = mem_q[rd_ptr_q];
  assign bus.rx_valid    = (count_q != '0);
  assign bus.rx_count    = count_q;
  assign bus.rx_overflow = rx_overflow_q;
  assign bus.tx_underrun = tx_underrun_q;
  assign bus.frame_abort = frame_abort_q;
endmodule

// File: tb/tb_spi_slave_fifo.sv
// tb/tb_spi_slave_fifo.sv - self-checking bench for spi_slave_fifo (8-bit MSB-first and 16-bit LSB-first)
module tb_spi_slave_fifo;
  logic sclk, rst;
  logic cs_a, mosi_a, cs_b, mosi_b;
  wire  miso_a, miso_b;
  int   checks = 0;
  int   failures = 0;

  // Pull-ups make a released MISO read as 1.
  pullup pu_a (miso_a);
  pullup pu_b (miso_b);

  spi_slave_fifo_if #(.WIDTH(8),  .RX_DEPTH(4)) ifa ();
  spi_slave_fifo_if #(.WIDTH(16), .RX_DEPTH(4)) ifb ();

  spi_slave_fifo #(.WIDTH(8), .RX_DEPTH(4), .LSB_FIRST(1'b0)) u_a (
    .SCLK(sclk), .reset(rst), .CS(cs_a), .MOSI(mosi_a), .MISO(miso_a), .bus(ifa));
  spi_slave_fifo #(.WIDTH(16), .RX_DEPTH(4), .LSB_FIRST(1'b1)) u_b (
    .SCLK(sclk), .reset(rst), .CS(cs_b), .MOSI(mosi_b), .MISO(miso_b), .bus(ifb));

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  typedef struct {
    logic       load;
    logic [7:0] tx;
    logic [7:0] mosi;
    logic       rd;
    logic       wr;
    logic [7:0] e_miso;
    int         e_cnt;
    logic       e_full;
    logic       e_und;
    logic       e_ovf;
  } vec_t;

  vec_t       tbl [6];
  logic       opt_pop, opt_clr, opt_txwr;
  logic [7:0] opt_txd;
  logic [7:0] got;
  logic [15:0] got_b;
  logic [7:0] mq [$];
  logic [7:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge sclk);
    @(negedge sclk);
  endtask

  task automatic frame_a(input logic [7:0] w, input int nb, output logic [7:0] g);
    g = '0;
    for (int i = 0; i < nb; i++) begin
      cs_a = 1'b0;
      mosi_a = w[7-i];
      ifa.rx_rd = opt_pop && (i == 7);
      ifa.clr_status = opt_clr && (i == 0);
      ifa.tx_wr = opt_txwr && (i == 0);
      if (opt_txwr) ifa.tx_data = opt_txd;
      #1 g = {g[6:0], miso_a};
      step();
    end
    ifa.rx_rd = 1'b0;
    ifa.clr_status = 1'b0;
    ifa.tx_wr = 1'b0;
  endtask

  task automatic idle_a();
    cs_a = 1'b1;
    step();
  endtask

  task automatic pop_a();
    cs_a = 1'b1;
    ifa.rx_rd = 1'b1;
    step();
    ifa.rx_rd = 1'b0;
  endtask

  initial begin
    tbl[0] = '{1'b1, 8'hA5, 8'h3C, 1'b1, 1'b1, 8'hA5, 1, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 8'h00, 8'h11, 1'b1, 1'b1, 8'h00, 2, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 8'h0F, 8'hFF, 1'b1, 1'b0, 8'h0F, 2, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 8'hC3, 8'h22, 1'b0, 1'b1, 8'hFF, 3, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 8'h00, 8'h44, 1'b1, 1'b1, 8'hC3, 4, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 8'h00, 8'h55, 1'b1, 1'b1, 8'h00, 4, 1'b0, 1'b1, 1'b1};

    opt_pop = 0; opt_clr = 0; opt_txwr = 0; opt_txd = '0;
    cs_a = 1; mosi_a = 0; cs_b = 1; mosi_b = 0;
    ifa.wr_en = 1; ifa.rd_en = 1; ifa.tx_data = '0; ifa.tx_wr = 0; ifa.rx_rd = 0; ifa.clr_status = 0;
    ifb.wr_en = 1; ifb.rd_en = 1; ifb.tx_data = '0; ifb.tx_wr = 0; ifb.rx_rd = 0; ifb.clr_status = 0;
    rst = 1;
    @(negedge sclk);
    @(negedge sclk);
    rst = 0;

    chk("reset rx_count", ifa.rx_count, 0);
    chk("reset rx_valid", ifa.rx_valid, 0);
    chk("reset rx_data", ifa.rx_data, 0);
    chk("reset tx_full", ifa.tx_full, 0);
    chk("reset flags", {ifa.rx_overflow, ifa.tx_underrun, ifa.frame_abort}, 0);
    cs_a = 0;
    #1 chk("reset miso driven", miso_a, 0);
    cs_a = 1;
    #1 chk("miso released cs high", miso_a, 1);

    for (int r = 0; r < 6; r++) begin
      cs_a = 1'b1;
      ifa.tx_wr = tbl[r].load;
      ifa.tx_data = tbl[r].tx;
      step();
      ifa.tx_wr = 1'b0;
      ifa.rd_en = tbl[r].rd;
      ifa.wr_en = tbl[r].wr;
      frame_a(tbl[r].mosi, 8, got);
      chk($sformatf("row%0d miso", r), got, tbl[r].e_miso);
      chk($sformatf("row%0d rx_count", r), ifa.rx_count, tbl[r].e_cnt);
      chk($sformatf("row%0d tx_full", r), ifa.tx_full, tbl[r].e_full);
      chk($sformatf("row%0d tx_underrun", r), ifa.tx_underrun, tbl[r].e_und);
      chk($sformatf("row%0d rx_overflow", r), ifa.rx_overflow, tbl[r].e_ovf);
      chk($sformatf("row%0d head", r), ifa.rx_data, 8'h3C);
    end

    // clear sticky flags
    cs_a = 1; ifa.clr_status = 1; step(); ifa.clr_status = 0;
    chk("clr overflow", ifa.rx_overflow, 0);
    chk("clr underrun", ifa.tx_underrun, 0);

    // push and pop on the same edge while full
    ifa.rd_en = 1; ifa.wr_en = 1; opt_pop = 1;
    frame_a(8'h66, 8, got);
    opt_pop = 0;
    chk("full push+pop count", ifa.rx_count, 4);
    chk("full push+pop no ovf", ifa.rx_overflow, 0);
    chk("full push+pop head", ifa.rx_data, 8'h11);

    // tx_wr on the consuming start edge
    ifa.wr_en = 0;
    cs_a = 1; ifa.tx_wr = 1; ifa.tx_data = 8'h96; step(); ifa.tx_wr = 0;
    opt_txwr = 1; opt_txd = 8'h69;
    frame_a(8'h00, 8, got);
    opt_txwr = 0;
    chk("refill old word", got, 8'h96);
    chk("refill tx_full", ifa.tx_full, 1);
    idle_a();
    frame_a(8'h00, 8, got);
    chk("refill new word", got, 8'h69);
    chk("refill consumed", ifa.tx_full, 0);

    exp_q = '{8'h11, 8'h22, 8'h44, 8'h66};
    foreach (exp_q[i]) begin
      chk("drain order", ifa.rx_data, exp_q[i]);
      pop_a();
    end
    chk("drained count", ifa.rx_count, 0);
    chk("drained valid", ifa.rx_valid, 0);

    // back-to-back frames, holding register empty
    cs_a = 1; ifa.clr_status = 1; step(); ifa.clr_status = 0;
    ifa.wr_en = 1; ifa.rd_en = 1;
    exp_q = '{8'h11, 8'h22, 8'h33};
    foreach (exp_q[i]) begin
      frame_a(exp_q[i], 8, got);
      chk("b2b miso zero", got, 0);
    end
    chk("b2b count", ifa.rx_count, 3);
    chk("b2b underrun", ifa.tx_underrun, 1);
    foreach (exp_q[i]) begin
      chk("b2b order", ifa.rx_data, exp_q[i]);
      pop_a();
    end

    // abort after 5 edges
    frame_a(8'hFF, 5, got);
    idle_a();
    chk("abort pulse", ifa.frame_abort, 1);
    chk("abort count", ifa.rx_count, 0);
    idle_a();
    chk("abort pulse width", ifa.frame_abort, 0);
    frame_a(8'h5A, 8, got);
    chk("post-abort count", ifa.rx_count, 1);
    chk("post-abort data", ifa.rx_data, 8'h5A);

    // clr_status beats an underrun set on the same edge
    idle_a();
    opt_clr = 1;
    frame_a(8'h77, 8, got);
    opt_clr = 0;
    chk("clr priority", ifa.tx_underrun, 0);

    // reset mid-frame with 3 entries and a loaded holding register
    frame_a(8'h88, 8, got);
    chk("pre-reset count", ifa.rx_count, 3);
    chk("pre-reset underrun", ifa.tx_underrun, 1);
    cs_a = 1; ifa.tx_wr = 1; ifa.tx_data = 8'hE7; step(); ifa.tx_wr = 0;
    ifa.rd_en = 0;
    frame_a(8'hAA, 3, got);
    ifa.rd_en = 1; cs_a = 0;
    rst = 1;
    #1;
    chk("midreset count", ifa.rx_count, 0);
    chk("midreset valid", ifa.rx_valid, 0);
    chk("midreset data", ifa.rx_data, 0);
    chk("midreset tx_full", ifa.tx_full, 0);
    chk("midreset flags", {ifa.rx_overflow, ifa.tx_underrun, ifa.frame_abort}, 0);
    chk("midreset miso", miso_a, 0);
    rst = 0; cs_a = 1;
    step();

    // randomized frames against a frame-level model
    begin
      logic [7:0] hold, sent, mosi, d;
      logic full, und, ovf, rden, wren, txw, rrd, clr;
      int nb;
      full = 0; und = 0; ovf = 0; hold = 0; mq.delete();
      for (int n = 0; n < 200; n++) begin
        txw = ($urandom % 3) == 0;
        rrd = ($urandom % 3) == 0;
        clr = ($urandom % 16) == 0;
        d = 8'($urandom);
        cs_a = 1; ifa.tx_wr = txw; ifa.tx_data = d; ifa.rx_rd = rrd; ifa.clr_status = clr;
        step();
        ifa.tx_wr = 0; ifa.rx_rd = 0; ifa.clr_status = 0;
        if (clr) begin ovf = 0; und = 0; end
        if (txw && !full) begin hold = d; full = 1; end
        if (rrd && mq.size() > 0) void'(mq.pop_front());

        rden = ($urandom % 4) != 0;
        wren = ($urandom % 5) != 0;
        nb = (($urandom % 8) == 0) ? $urandom_range(1, 7) : 8;
        mosi = 8'($urandom);
        ifa.rd_en = rden; ifa.wr_en = wren;
        sent = 8'hFF;
        if (rden) begin
          sent = full ? hold : 8'h00;
          if (!full) und = 1;
          full = 0;
        end
        frame_a(mosi, nb, got);
        if (nb == 8 && wren) begin
          if (mq.size() == 4) ovf = 1;
          else mq.push_back(mosi);
        end
        chk($sformatf("rnd%0d miso", n), got, sent >> (8 - nb));
        chk($sformatf("rnd%0d count", n), ifa.rx_count, mq.size());
        chk($sformatf("rnd%0d flags", n), {ifa.tx_full, ifa.tx_underrun, ifa.rx_overflow}, {full, und, ovf});
        if (mq.size() > 0) chk($sformatf("rnd%0d head", n), ifa.rx_data, mq[0]);
      end
    end
    cs_a = 1;

    // 16-bit LSB-first instance
    begin
      logic [15:0] w;
      w = 16'h1234;
      ifb.tx_data = 16'h8001; ifb.tx_wr = 1; step(); ifb.tx_wr = 0;
      got_b = '0;
      for (int i = 0; i < 16; i++) begin
        cs_b = 0;
        mosi_b = w[i];
        #1 got_b[i] = miso_b;
        step();
      end
      cs_b = 1;
      chk("lsb miso", got_b, 16'h8001);
      chk("lsb count", ifb.rx_count, 1);
      chk("lsb rx_data", ifb.rx_data, 16'h1234);
      chk("lsb tx_full", ifb.tx_full, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/spi_slave_fifo.md
# spi_slave_fifo

Parametrised SPI slave, successor to the fixed 8-bit shift-on-SCLK slave. Word width and bit order are configurable. A single TX holding register and an RX FIFO decouple the host from frame timing. Frames run back-to-back with CS held low, and overflow, underrun and abort are reported as status flags. It sits between the SPI pins and the host-side register/bus logic. All logic runs on SCLK, which is treated as the block's free-running clock, and CS and MOSI are sampled synchronously.

## Interface
- WIDTH, 8, bits per SPI word (≥2).
- RX_DEPTH, 4, RX FIFO entries (power of 2, ≥2).
- LSB_FIRST, 0, 0 = MSB shifted first on both MOSI and MISO; 1 = LSB first.

- SCLK  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- CS  in  1  chip select, active low, sampled at posedge SCLK.
- MOSI  in  1  serial data in, sampled at posedge SCLK.
- MISO  out  1  serial data out; driven only when CS==0 and rd_en==1, otherwise high-Z.
- wr_en  in  1  1 = received words are pushed to the RX FIFO.
- rd_en  in  1  1 = MISO driven and the TX word is consumed.
- tx_data  in  WIDTH  word for the next frame.
- tx_wr  in  1  load tx_data into the holding register.
- tx_full  out  1  holding register occupied.
- rx_data  out  WIDTH  RX FIFO head, valid when rx_valid==1.
- rx_valid  out  1  RX FIFO not empty.
- rx_rd  in  1  pop the RX FIFO head; ignored when empty.
- rx_count  out  clog2(RX_DEPTH+1)  RX FIFO occupancy.
- rx_overflow  out  1  sticky: a word was dropped because the FIFO was full.
- tx_underrun  out  1  sticky: a frame started with the holding register empty and rd_en==1.
- frame_abort  out  1  one-cycle pulse: CS rose mid-frame.
- clr_status  in  1  clears rx_overflow and tx_underrun.

## Operation
- **States.**
  - IDLE: bit_cnt=0.
  - SHIFT: bit_cnt 1..WIDTH-1.
- **IDLE, CS==0 at posedge (start edge):**
  - First MOSI bit goes into rx_shift.
  - tx_shift ← tx_hold (or 0 if empty), shifted by one position.
  - tx_full cleared if rd_en; tx_underrun set if rd_en and the holding register is empty.
  - bit_cnt←1, go to SHIFT.
- **SHIFT, CS==0:** capture MOSI, shift tx_shift, bit_cnt++. When the edge capturing bit WIDTH-1 completes:
  - Assembled word is pushed to the RX FIFO if wr_en.
  - Return to IDLE. If CS is still low, the next posedge is a new start edge, so there is no gap between words.
- **SHIFT, CS==1 at posedge:** go to IDLE, bit_cnt←0, partial word discarded, frame_abort=1 for one cycle. tx_hold was already consumed at the start edge and is not restored.
- **MISO source:**
  - IDLE: the first bit of tx_hold (0 if empty).
  - SHIFT: the leading bit of tx_shift, which is bit WIDTH-1 when LSB_FIRST=0 and bit 0 otherwise.
- **MOSI assembly:**
  - LSB_FIRST=0: left shift, new bit into bit 0.
  - LSB_FIRST=1: right shift, new bit into bit WIDTH-1.
- **RX FIFO:** circular, pointers wrap modulo RX_DEPTH.
  - Push while full, no pop in the same cycle: word dropped, rx_overflow set.
  - Push and pop in the same cycle while full: both happen, count unchanged, no overflow.
  - Push and pop in the same cycle while empty: push only.
- **TX holding register:**
  - tx_wr while tx_full and not consumed that cycle: ignored.
  - tx_wr in the same cycle as consumption at a start edge: the old word goes to the frame, the new word is stored, tx_full stays 1.
- **Status flags:** clr_status takes priority over a simultaneous set, so the flag reads 0 the next cycle.
- **Parameter checks:** an illegal WIDTH or RX_DEPTH is caught at elaboration.

## Timing
- **Reset values:** state=IDLE, bit_cnt=0, tx_full=0, rx_count=0, rx_valid=0, rx_data=0, rx_overflow=0, tx_underrun=0, frame_abort=0, FIFO pointers 0. MISO is high-Z unless CS==0 and rd_en==1, in which case it drives 0.
- **Reset mid-frame:** returns to IDLE immediately and asynchronously; partial data is lost and the FIFO is emptied.
- **Frame length:** WIDTH posedges with CS low.
- **RX latency:** rx_valid rises the cycle after the edge capturing bit WIDTH-1.
- **Bus-side updates:** tx_full rises the cycle after tx_wr. rx_data reflects the new head the cycle after rx_rd.
- **MISO:** combinational from the registered state. Bit k is stable from after posedge k-1 until posedge k, so the master samples it on posedge k.

## Test plan
- **Basic transfer (WIDTH=8, MSB first):** tx_wr 0xA5, CS low for 8 edges, MOSI=0x3C → MISO emits 1,0,1,0,0,1,0,1; rx_data=0x3C, rx_count=1, tx_full=0.
- **Back-to-back frames:** CS low for 24 edges, MOSI 0x11,0x22,0x33, tx_hold empty → 3 FIFO entries in order, tx_underrun=1, MISO all 0.
- **Overflow (RX_DEPTH=4):** 5 frames with no rx_rd → rx_count=4, rx_overflow=1, fifth word dropped. clr_status → 0. With 4 entries, a pop on the push cycle → count stays 4, no overflow.
- **Abort:** CS high after 5 edges → frame_abort pulse, rx_count unchanged. The next full frame 0x5A is received correctly.
- **LSB_FIRST=1, WIDTH=16:** tx 0x8001 → MISO 1,0…0,1; MOSI 0x1234 sent LSB-first → rx_data=0x1234.
- **Reset and enables:** reset asserted mid-frame with 3 FIFO entries → all outputs at reset values. With wr_en=0 no push occurs; with rd_en=0 MISO is high-Z and tx_full stays 1.
